ether_rx: RTL and testbench
===========================

Name: ether_rx

Overview:
- RMII receive front end.
- Watches the PHY carrier-sense/data-valid (crsdv) and 2-bit receive data (rxd) on the 50 MHz RMII clock.
- Checks and strips the Ethernet preamble and SFD, then streams the frame's payload dibits out on a simple valid/data AXI-Stream-style interface.
- Sits between the RMII PHY pins and downstream frame logic (bit-order, FCS, address filtering).

Parameters:
- PREAMBLE_LEN, 31, number of preamble/SFD dibits that must equal PREAMBLE_DIBIT before the SFD terminator.
- PREAMBLE_DIBIT, 2'b01, expected value of each preamble dibit (0x55 sent LSB-first).
- SFD_LAST, 2'b11, final dibit of the SFD that marks start of payload.

Ports:
- clk  input  1  RMII reference clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- crsdv  input  1  RMII carrier sense / data valid.
- rxd  input  2  RMII receive dibit.
- axiov  output  1  payload dibit valid.
- axiod  output  2  payload dibit.

Behaviour:
- One clock; reset is asynchronous and active-low (rst low → immediate reset).
- Reset values: axiov=0, axiod=2'b00, state=IDLE, preamble counter=0.
- axiov and axiod are registered, giving 1-cycle latency from a sampled payload dibit to its output.
- States: IDLE, PREAMBLE, DATA, BAD.
- IDLE:
  - crsdv=0: stay.
  - crsdv=1 and rxd==PREAMBLE_DIBIT: go to PREAMBLE with count=1.
  - crsdv=1 and rxd!=PREAMBLE_DIBIT: go to BAD.
- PREAMBLE:
  - crsdv=0 at any time: go to IDLE (aborted frame).
  - count<PREAMBLE_LEN and rxd==PREAMBLE_DIBIT: count++.
  - count<PREAMBLE_LEN and rxd!=PREAMBLE_DIBIT: go to BAD.
  - count==PREAMBLE_LEN and rxd==SFD_LAST: go to DATA (SFD dibit is not output).
  - count==PREAMBLE_LEN and any other rxd: go to BAD.
  - The counter is 5 bits and saturates; it never wraps.
- DATA:
  - crsdv=1: next cycle axiov=1 and axiod=current rxd.
  - crsdv=0: next cycle axiov=0, and go to IDLE.
  - Mid-frame crsdv toggling (RMII false-carrier/CRS recovery) is not modelled; the first crsdv=0 ends the frame.
- BAD:
  - axiov held 0.
  - Stay until crsdv=0, then go to IDLE.
  - A frame whose preamble fails is dropped entirely, even if a valid preamble follows while crsdv stays high.
- axiov is 0 in every state other than DATA.
- axiod holds its last value when axiov=0. Downstream logic must ignore axiod unless axiov=1.
- Reset asserted mid-frame: outputs clear immediately. After release, the block starts in IDLE and needs a fresh crsdv rising sequence to recover.
- Frame length is not limited; DATA runs as long as crsdv=1.

Decomposition:
- Shared package ether_pkg:
  - state enum (IDLE, PREAMBLE, DATA, BAD);
  - constants PREAMBLE_DIBIT, SFD_LAST, PREAMBLE_LEN.
- Single flat module. The FSM and counter are small enough that no sub-module is warranted.

Test Plan:
- Reset: hold rst=0 with crsdv=1, rxd=2'b11 → axiov=0, axiod=2'b00 throughout.
- Good frame:
  - Stimulus: 31 dibits of 2'b01, then 2'b11, then payload pattern 11,01,01 repeated for 6040 dibits, then crsdv=0.
  - Required: axiov=1 starting one cycle after the first payload dibit, and axiod reproducing the pattern exactly with 1-cycle delay.
  - Required: exactly 6040 valid cycles, and axiov=0 one cycle after crsdv falls.
- Bad start: crsdv=1 with rxd 11,00,01, then a correct preamble/SFD/payload with crsdv kept high → axiov stays 0 for the whole burst. After crsdv=0 and then a clean frame, the payload is output normally.
- Corrupted preamble: 2'b01 ×10, then 2'b10 → BAD, axiov=0 until crsdv drops.
- Wrong SFD: 2'b01 ×31, then 2'b01 → BAD, no output.
- Abort: crsdv falls after 15 preamble dibits → IDLE. The next clean frame is received correctly.

Source files
------------

// File: rtl/ether_pkg.sv
// ether_pkg: shared FSM states and RMII preamble/SFD constants for ether_rx.
package ether_pkg;
   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, BAD} state_t;
   localparam logic [4:0] PREAMBLE_LEN   = 5'd31;
   localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0] SFD_LAST       = 2'b11;
endpackage

// File: rtl/ether_rx.sv
// ether_rx: RMII receive front end; strips preamble/SFD and streams payload dibits.
module ether_rx
   import ether_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       crsdv,
   input  logic [1:0] rxd,
   output logic       axiov,
   output logic [1:0] axiod
);
   state_t     state;
   logic [4:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         cnt   <= 5'd0;
         axiov <= 1'b0;
         axiod <= 2'b00;
      end else begin
         axiov <= 1'b0;
         case (state)
            IDLE: if (crsdv) begin
               state <= (rxd == PREAMBLE_DIBIT) ? PREAMBLE : BAD;
               cnt   <= 5'd1;
            end
            PREAMBLE:
               if (!crsdv) state <= IDLE;
               else if (cnt < PREAMBLE_LEN) begin
                  if (rxd == PREAMBLE_DIBIT) cnt <= cnt + 5'd1;
                  else state <= BAD;
               end else state <= (rxd == SFD_LAST) ? DATA : BAD;
            DATA:
               if (crsdv) begin
                  axiov <= 1'b1;
                  axiod <= rxd;
               end else state <= IDLE;
            BAD: if (!crsdv) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_ether_rx.sv
// tb_ether_rx: directed self-checking bench for the ether_rx RMII receiver.
module tb_ether_rx;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       crsdv = 1'b0;
   logic [1:0] rxd = 2'b00;
   logic       axiov;
   logic [1:0] axiod;
   int         tests = 0;
   int         fails = 0;

   ether_rx dut (.clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd), .axiov(axiov), .axiod(axiod));

   always #10 clk = ~clk;

   task automatic send(input logic c, input logic [1:0] d);
      @(negedge clk);
      crsdv = c;
      rxd   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic pre(input int n);
      for (int i = 0; i < n; i++) send(1'b1, 2'b01);
   endtask

   task automatic test_reset();
      rst = 1'b0; crsdv = 1'b1; rxd = 2'b11;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         tests++;
         if (axiov !== 1'b0 || axiod !== 2'b00) begin
            fails++;
            $display("FAIL reset: axiov=%b axiod=%b, required 0/00", axiov, axiod);
         end
      end
      @(negedge clk);
      crsdv = 1'b0;
      rst = 1'b1;
      send(1'b0, 2'b00);
   endtask

   task automatic test_good_frame();
      logic [1:0] d;
      int nv = 0;
      pre(31);
      send(1'b1, 2'b11);
      tests++;
      if (axiov !== 1'b0) begin
         fails++;
         $display("FAIL good_sfd: axiov=%b, required 0", axiov);
      end
      for (int i = 0; i < 6040; i++) begin
         d = (i % 3 == 0) ? 2'b11 : 2'b01;
         send(1'b1, d);
         if (axiov === 1'b1) nv++;
         tests++;
         if (axiov !== 1'b1 || axiod !== d) begin
            fails++;
            $display("FAIL good_payload[%0d]: axiov=%b axiod=%b, required 1/%b", i, axiov, axiod, d);
         end
      end
      send(1'b0, 2'b10);
      tests++;
      if (axiov !== 1'b0 || axiod !== 2'b11) begin
         fails++;
         $display("FAIL good_end: axiov=%b axiod=%b, required 0/11 (held)", axiov, axiod);
      end
      tests++;
      if (nv != 6040) begin
         fails++;
         $display("FAIL good_count: valid cycles=%0d, required 6040", nv);
      end
      send(1'b0, 2'b00);
   endtask

   task automatic test_bad_start();
      logic [1:0] pl [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
      int nv = 0;
      send(1'b1, 2'b11); send(1'b1, 2'b00); send(1'b1, 2'b01);
      if (axiov === 1'b1) nv++;
      for (int i = 0; i < 31; i++) begin
         send(1'b1, 2'b01);
         if (axiov === 1'b1) nv++;
      end
      send(1'b1, 2'b11);
      if (axiov === 1'b1) nv++;
      for (int i = 0; i < 10; i++) begin
         send(1'b1, 2'b10);
         if (axiov === 1'b1) nv++;
      end
      tests++;
      if (nv != 0) begin
         fails++;
         $display("FAIL bad_start: valid cycles=%0d, required 0", nv);
      end
      send(1'b0, 2'b00);
      pre(31);
      send(1'b1, 2'b11);
      for (int i = 0; i < 4; i++) begin
         send(1'b1, pl[i]);
         tests++;
         if (axiov !== 1'b1 || axiod !== pl[i]) begin
            fails++;
            $display("FAIL bad_start_recover[%0d]: axiov=%b axiod=%b, required 1/%b", i, axiov, axiod, pl[i]);
         end
      end
      send(1'b0, 2'b00);
      tests++;
      if (axiov !== 1'b0) begin
         fails++;
         $display("FAIL bad_start_end: axiov=%b, required 0", axiov);
      end
   endtask

   task automatic test_corrupt_preamble();
      int nv = 0;
      pre(10);
      send(1'b1, 2'b10);
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 2'b01);
         if (axiov === 1'b1) nv++;
      end
      send(1'b1, 2'b11);
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 2'b11);
         if (axiov === 1'b1) nv++;
      end
      tests++;
      if (nv != 0) begin
         fails++;
         $display("FAIL corrupt_preamble: valid cycles=%0d, required 0", nv);
      end
      send(1'b0, 2'b00);
      tests++;
      if (axiov !== 1'b0) begin
         fails++;
         $display("FAIL corrupt_end: axiov=%b, required 0", axiov);
      end
   endtask

   task automatic test_wrong_sfd();
      int nv = 0;
      pre(31);
      send(1'b1, 2'b01);
      if (axiov === 1'b1) nv++;
      for (int i = 0; i < 6; i++) begin
         send(1'b1, 2'b10);
         if (axiov === 1'b1) nv++;
      end
      tests++;
      if (nv != 0) begin
         fails++;
         $display("FAIL wrong_sfd: valid cycles=%0d, required 0", nv);
      end
      send(1'b0, 2'b00);
   endtask

   task automatic test_abort();
      logic [1:0] pl [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
      pre(15);
      send(1'b0, 2'b00);
      tests++;
      if (axiov !== 1'b0) begin
         fails++;
         $display("FAIL abort: axiov=%b, required 0", axiov);
      end
      pre(31);
      send(1'b1, 2'b11);
      for (int i = 0; i < 4; i++) begin
         send(1'b1, pl[i]);
         tests++;
         if (axiov !== 1'b1 || axiod !== pl[i]) begin
            fails++;
            $display("FAIL abort_recover[%0d]: axiov=%b axiod=%b, required 1/%b", i, axiov, axiod, pl[i]);
         end
      end
      send(1'b0, 2'b00);
   endtask

   task automatic test_mid_reset();
      pre(31);
      send(1'b1, 2'b11);
      send(1'b1, 2'b10);
      tests++;
      if (axiov !== 1'b1 || axiod !== 2'b10) begin
         fails++;
         $display("FAIL mid_reset_pre: axiov=%b axiod=%b, required 1/10", axiov, axiod);
      end
      #3 rst = 1'b0;
      #1;
      tests++;
      if (axiov !== 1'b0 || axiod !== 2'b00) begin
         fails++;
         $display("FAIL mid_reset_async: axiov=%b axiod=%b, required 0/00", axiov, axiod);
      end
      @(negedge clk);
      rst = 1'b1;
      send(1'b1, 2'b11);
      send(1'b1, 2'b11);
      tests++;
      if (axiov !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_after: axiov=%b, required 0", axiov);
      end
      send(1'b0, 2'b00);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_start();
      test_corrupt_preamble();
      test_wrong_sfd();
      test_abort();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
